// File: rtl/fpga250_cfg_pkg.sv
// Shared configuration package for the fpga250 switch-box fabric.
// Holds chain-geometry derivations, switch bit positions and the loader FSM states.
package fpga250_cfg_pkg;

    // Loader state: nothing shifted, partially shifted, full frame set present
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_FULL    = 2'd2
    } sb_state_e;

    // Six pass switches per junction; bit offsets inside a junction's field
    localparam int SB_SW_PER_JCT = 32'sd6;
    localparam int SW_NE = 32'sd0;
    localparam int SW_NS = 32'sd1;
    localparam int SW_NW = 32'sd2;
    localparam int SW_ES = 32'sd3;
    localparam int SW_EW = 32'sd4;
    localparam int SW_SW = 32'sd5;

    // Config bits: one junction per single track, one per pair of double tracks
    function automatic int sb_conf_w(input int ws, input int wd);
        return (ws + wd / 32'sd2) * SB_SW_PER_JCT;
    endfunction

    // Config bits plus the parity bit, padded up to whole frames
    function automatic int sb_chain_w(input int ws, input int wd, input int lanes);
        return ((sb_conf_w(ws, wd) + 32'sd1 + lanes - 32'sd1) / lanes) * lanes;
    endfunction

    // Number of LANES-wide frames that fill the chain
    function automatic int sb_frames(input int ws, input int wd, input int lanes);
        return sb_chain_w(ws, wd, lanes) / lanes;
    endfunction

endpackage

// File: rtl/clb_switch_box.sv
// Switch box: six pass switches per junction, configured by the active register.
// Signal direction is fixed N -> E -> S -> W so the track nets never form a loop;
// a side that no enabled switch drives is left high-impedance.
module clb_switch_box
    import fpga250_cfg_pkg::*;
#(
    parameter int WS = 4,
    parameter int WD = 8
) (
    input  logic [(WS+WD/2)*6-1:0] cfg_i,
    inout  wire  [WS-1:0]          north_single,
    inout  wire  [WS-1:0]          east_single,
    inout  wire  [WS-1:0]          south_single,
    inout  wire  [WS-1:0]          west_single,
    inout  wire  [WD-1:0]          north_double,
    inout  wire  [WD-1:0]          east_double,
    inout  wire  [WD-1:0]          south_double,
    inout  wire  [WD-1:0]          west_double
);

    // One junction per single track
    for (genvar i = 0; i < WS; i++) begin : g_single
        localparam int B = i * SB_SW_PER_JCT;
        assign east_single[i]  = cfg_i[B+SW_NE] ? north_single[i] : 1'bz;
        assign south_single[i] = cfg_i[B+SW_NS] ? north_single[i] :
                                 cfg_i[B+SW_ES] ? east_single[i]  : 1'bz;
        assign west_single[i]  = cfg_i[B+SW_NW] ? north_single[i] :
                                 cfg_i[B+SW_EW] ? east_single[i]  :
                                 cfg_i[B+SW_SW] ? south_single[i] : 1'bz;
    end

    // Even double tracks end at this box and switch; odd ones run straight through
    for (genvar j = 0; j < WD / 2; j++) begin : g_double
        localparam int B = (WS + j) * SB_SW_PER_JCT;
        localparam int T = 2 * j;
        assign east_double[T]    = cfg_i[B+SW_NE] ? north_double[T] : 1'bz;
        assign south_double[T]   = cfg_i[B+SW_NS] ? north_double[T] :
                                   cfg_i[B+SW_ES] ? east_double[T]  : 1'bz;
        assign west_double[T]    = cfg_i[B+SW_NW] ? north_double[T] :
                                   cfg_i[B+SW_EW] ? east_double[T]  :
                                   cfg_i[B+SW_SW] ? south_double[T] : 1'bz;
        assign south_double[T+1] = north_double[T+1];
        assign west_double[T+1]  = east_double[T+1];
    end

endmodule

// File: rtl/sb_config_multilane.sv
// Multi-lane configuration loader for one switch box: a shadow shift chain is
// filled LANES bits per cycle, parity-checked, then committed to an active
// register that drives the switch box.
module sb_config_multilane
    import fpga250_cfg_pkg::*;
#(
    parameter int WS    = 4,
    parameter int WD    = 8,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [LANES-1:0] shift_in,
    output logic [LANES-1:0] shift_out,
    input  logic             set_in,
    output logic             set_done,
    output logic             cfg_err,
    output logic             cfg_valid,
    inout  wire  [WS-1:0]    north_single,
    inout  wire  [WS-1:0]    east_single,
    inout  wire  [WS-1:0]    south_single,
    inout  wire  [WS-1:0]    west_single,
    inout  wire  [WD-1:0]    north_double,
    inout  wire  [WD-1:0]    east_double,
    inout  wire  [WD-1:0]    south_double,
    inout  wire  [WD-1:0]    west_double
);

    localparam int CONF_W  = sb_conf_w(WS, WD);
    localparam int CHAIN_W = sb_chain_w(WS, WD, LANES);
    localparam int FRAMES  = sb_frames(WS, WD, LANES);
    localparam int CNT_W   = $clog2(FRAMES + 1);
    localparam logic [CNT_W-1:0] FRAMES_C = CNT_W'(FRAMES);

    // Config bits plus parity must XOR to zero
    function automatic logic parity_ok(input logic [CONF_W:0] bits);
        return ~(^bits);
    endfunction

    logic [CHAIN_W-1:0]       chain_q,     chain_d;
    logic [CONF_W-1:0]        active_q,    active_d;
    logic [CNT_W-1:0]         cnt_q,       cnt_d;
    sb_state_e                state_q,     state_d;
    logic [LANES-1:0]         shift_out_q, shift_out_d;
    logic                     set_done_q,  set_done_d;
    logic                     cfg_err_q,   cfg_err_d;
    logic                     cfg_valid_q, cfg_valid_d;
    logic [CHAIN_W+LANES-1:0] shifted_s;
    logic                     commit_s;
    logic                     accept_s;

    assign shifted_s = {shift_in, chain_q};
    // A commit request during a shift is ignored; the shift wins
    assign commit_s  = set_in & ~cen;
    assign accept_s  = commit_s & (state_q == ST_FULL) & parity_ok(chain_q[CONF_W:0]);

    // Next-state logic for chain, frame counter, loader FSM and commit status
    always_comb begin
        chain_d     = chain_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        shift_out_d = shift_out_q;
        active_d    = active_q;
        set_done_d  = 1'b0;
        cfg_err_d   = cfg_err_q;
        cfg_valid_d = cfg_valid_q;
        if (cen) begin
            chain_d     = shifted_s[CHAIN_W+LANES-1:LANES];
            shift_out_d = chain_q[LANES-1:0];
            if (cnt_q == FRAMES_C) begin
                cnt_d = FRAMES_C;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            chain_d = chain_q;
        end
        if (commit_s) begin
            // Any attempt restarts loading; the shadow chain itself is kept for readback
            state_d = ST_EMPTY;
            cnt_d   = '0;
            if (accept_s) begin
                active_d    = chain_q[CONF_W-1:0];
                set_done_d  = 1'b1;
                cfg_err_d   = 1'b0;
                cfg_valid_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (cen) begin
                        state_d = (cnt_d == FRAMES_C) ? ST_FULL : ST_LOADING;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_LOADING: begin
                    if (cnt_d == FRAMES_C) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_LOADING;
                    end
                end
                ST_FULL:  state_d = ST_FULL;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // State registers with asynchronous reset to power-on values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q     <= '0;
            active_q    <= '0;
            cnt_q       <= '0;
            state_q     <= ST_EMPTY;
            shift_out_q <= '0;
            set_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_valid_q <= 1'b0;
        end else begin
            chain_q     <= chain_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            shift_out_q <= shift_out_d;
            set_done_q  <= set_done_d;
            cfg_err_q   <= cfg_err_d;
            cfg_valid_q <= cfg_valid_d;
        end
    end

    assign shift_out = shift_out_q;
    assign set_done  = set_done_q;
    assign cfg_err   = cfg_err_q;
    assign cfg_valid = cfg_valid_q;

    clb_switch_box #(
        .WS (WS),
        .WD (WD)
    ) u_switch_box (
        .cfg_i        (active_q),
        .north_single (north_single),
        .east_single  (east_single),
        .south_single (south_single),
        .west_single  (west_single),
        .north_double (north_double),
        .east_double  (east_double),
        .south_double (south_double),
        .west_double  (west_double)
    );

endmodule

// File: tb/tb_sb_config_multilane.sv
// Directed + randomized bench for sb_config_multilane (WS=4, WD=8, LANES=4).
// Reference model: a FIFO of the last FRAMES frames shifted in, a saturating
// frame count and the commit rules; the expected state is derived from the count.
module tb_sb_config_multilane;
    import fpga250_cfg_pkg::*;

    localparam int WS = 4, WD = 8, LANES = 4;
    localparam int CONF_W = 48, CHAIN_W = 52, FRAMES = 13;

    logic       clk = 1'b0;
    logic       rst, cen, set_in;
    logic [3:0] shift_in;
    logic [3:0] shift_out;
    logic       set_done, cfg_err, cfg_valid;
    logic [3:0] n_single_drv;
    logic [7:0] n_double_drv;
    wire  [3:0] north_single, east_single, south_single, west_single;
    wire  [7:0] north_double, east_double, south_double, west_double;

    assign north_single = n_single_drv;
    assign north_double = n_double_drv;

    always #5 clk = ~clk;

    sb_config_multilane #(.WS(WS), .WD(WD), .LANES(LANES)) dut (
        .clk          (clk),
        .rst          (rst),
        .cen          (cen),
        .shift_in     (shift_in),
        .shift_out    (shift_out),
        .set_in       (set_in),
        .set_done     (set_done),
        .cfg_err      (cfg_err),
        .cfg_valid    (cfg_valid),
        .north_single (north_single),
        .east_single  (east_single),
        .south_single (south_single),
        .west_single  (west_single),
        .north_double (north_double),
        .east_double  (east_double),
        .south_double (south_double),
        .west_double  (west_double)
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [3:0]        hist[$];
    int                m_cnt;
    logic [CONF_W-1:0] m_active;
    logic              m_valid, m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CHAIN_W-1:0] model_chain();
        logic [CHAIN_W-1:0] img;
        img = '0;
        for (int k = 0; k < FRAMES; k++) img[4*k +: 4] = hist[k];
        return img;
    endfunction

    function automatic sb_state_e model_state();
        if (m_cnt == 0) return ST_EMPTY;
        else if (m_cnt == FRAMES) return ST_FULL;
        else return ST_LOADING;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < FRAMES; k++) hist.push_back(4'h0);
        m_cnt    = 0;
        m_active = '0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_cfg_err"},   64'(cfg_err),       64'(m_err));
        check({tag, "_cfg_valid"}, 64'(cfg_valid),     64'(m_valid));
        check({tag, "_active"},    64'(dut.active_q),  64'(m_active));
        check({tag, "_cnt"},       64'(dut.cnt_q),     64'(m_cnt));
        check({tag, "_state"},     64'(dut.state_q),   64'(model_state()));
    endtask

    // One frame shifted; with_set also raises set_in in the same cycle
    task automatic shift_frame(input logic [3:0] f, input logic with_set);
        logic [3:0] exp_out;
        cen = 1'b1; shift_in = f; set_in = with_set;
        @(posedge clk); #1;
        cen = 1'b0; set_in = 1'b0; shift_in = 4'h0;
        exp_out = hist.pop_front();
        hist.push_back(f);
        if (m_cnt < FRAMES) m_cnt++;
        check("shift_out", 64'(shift_out), 64'(exp_out));
        check("set_done_during_shift", 64'(set_done), 64'(0));
    endtask

    task automatic load_image(input logic [CONF_W-1:0] cfg, input int nfr, input int flip_bit);
        logic [CHAIN_W-1:0] img;
        int pre;
        img = {3'b000, ^cfg, cfg};
        if (flip_bit >= 0) img[flip_bit] = ~img[flip_bit];
        pre = (nfr > FRAMES) ? nfr - FRAMES : 0;
        for (int j = 0; j < pre; j++) shift_frame(4'($urandom_range(0, 15)), 1'b0);
        for (int k = 0; k < nfr - pre; k++) shift_frame(img[4*k +: 4], 1'b0);
    endtask

    task automatic commit(input string tag);
        logic [CHAIN_W-1:0] img;
        logic ok;
        set_in = 1'b1; cen = 1'b0;
        @(posedge clk); #1;
        set_in = 1'b0;
        img = model_chain();
        ok  = (m_cnt == FRAMES) && ((^img[CONF_W:0]) == 1'b0);
        if (ok) begin
            m_active = img[CONF_W-1:0];
            m_valid  = 1'b1;
            m_err    = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        m_cnt = 0;
        check({tag, "_set_done"}, 64'(set_done), 64'(ok));
        check_status(tag);
        @(posedge clk); #1;
        check({tag, "_set_done_end"}, 64'(set_done), 64'(0));
    endtask

    function automatic logic [CONF_W-1:0] rand_cfg();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[CONF_W-1:0];
    endfunction

    task automatic check_routing();
        logic [3:0] ne_m, ns_m;
        logic [7:0] dne_m;
        n_single_drv = 4'($urandom_range(0, 15));
        n_double_drv = 8'($urandom_range(0, 255));
        ne_m = '0; ns_m = '0; dne_m = '0;
        for (int i = 0; i < WS; i++) begin
            ne_m[i] = m_active[6*i + 0];
            ns_m[i] = m_active[6*i + 1];
        end
        for (int j = 0; j < WD / 2; j++) dne_m[2*j] = m_active[6*(WS + j) + 0];
        #1;
        check("route_east_single",  64'(east_single & ne_m),  64'(n_single_drv & ne_m));
        check("route_south_single", 64'(south_single & ns_m), 64'(n_single_drv & ns_m));
        check("route_east_double",  64'(east_double & dne_m), 64'(n_double_drv & dne_m));
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; set_in = 1'b0; shift_in = 4'h0;
        n_single_drv = 4'h0; n_double_drv = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_shift_out", 64'(shift_out), 64'(0));
        check("reset_set_done",  64'(set_done),  64'(0));
        check_status("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Full load with good parity, then commit
        load_image(rand_cfg(), FRAMES, -1);
        check("full_state", 64'(dut.state_q), 64'(ST_FULL));
        commit("good_commit");
        check_routing();

        // Only 12 frames: rejected, active register kept
        load_image(rand_cfg(), FRAMES - 1, -1);
        commit("short_load");

        // One config bit corrupted: rejected
        load_image(rand_cfg(), FRAMES, int'($urandom_range(0, CONF_W - 1)));
        commit("bad_parity");

        // Good reload clears the error
        load_image(rand_cfg(), FRAMES, -1);
        commit("recover");
        check_routing();

        // Readback: shift zeros, committed frames come out LSB first
        for (int k = 0; k < FRAMES; k++) shift_frame(4'h0, 1'b0);
        check_status("readback");

        // set_in with cen in FULL: shift only, no commit
        shift_frame(4'($urandom_range(0, 15)), 1'b1);
        check_status("set_with_cen");
        shift_frame(4'h0, 1'b0);

        // Reset in the middle of a load
        load_image(rand_cfg(), 7, -1);
        rst = 1'b1;
        #2;
        model_reset();
        check("midrst_shift_out", 64'(shift_out), 64'(0));
        check("midrst_set_done",  64'(set_done),  64'(0));
        check_status("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_status("post_rst");
        load_image(rand_cfg(), FRAMES, -1);
        commit("after_rst");

        // Randomized loads: frame count, corruption and extra frames vary
        for (int it = 0; it < 6; it++) begin
            int nfr, flip;
            nfr  = int'($urandom_range(10, 16));
            flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, CONF_W)) : -1;
            load_image(rand_cfg(), nfr, flip);
            commit("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
